psram_xfer_arb: RTL and testbench
=================================

PSRAM_XFER_ARB -- requirements
Module: psram_xfer_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'hFFFF: watchdog limit in clk_i cycles; used only with PSRAM_ARB_WDT_EN.
REQ-002 clk_i  in  1  single block clock; all logic on rising edge.
REQ-003 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-004 arb_en_i  in  1  grant enable; 0 blocks new grants and does not abort an in-flight transfer.
REQ-005 reqN_valid_i  in  1  request from port N, N = 0,1.
REQ-006 reqN_rdwr_i  in  1  1 = read, 0 = write.
REQ-007 reqN_addr_i  in  32  transfer address.
REQ-008 reqN_wr_data_i  in  64  write data.
REQ-009 reqN_wr_mask_i  in  8  byte write mask.
REQ-010 reqN_ready_o  out  1  one-cycle accept pulse.
REQ-011 reqN_rd_data_o  out  64  read data, held until the next completion on port N.
REQ-012 reqN_done_o  out  1  one-cycle completion pulse.
REQ-013 reqN_err_o  out  1  timeout flag, valid with reqN_done_o.
REQ-014 core_addr_o 32, core_wr_data_o 64, core_wr_mask_o 8, core_rdwr_o 1, core_valid_o 1  out  registered request to the psram core.
REQ-015 core_ready_i 1, core_done_i 1, core_rd_data_i 64  in  core idle level, core completion pulse, core read data.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE -> ISSUE when arb_en_i & core_ready_i & (req0_valid_i | req1_valid_i).
- In that cycle: reqG_ready_o = 1 for the winner G; winner's rdwr/addr/wr_data/wr_mask latched into core_* registers.
REQ-018 Arbitration: round-robin.
- Single requester wins.
- Both valid: the port not granted last wins.
- Last-grant pointer resets to 1, so port 0 wins the first tie.
REQ-019 ISSUE: core_valid_o = 1 for exactly one cycle; next state WAIT.
REQ-020 core_addr_o, core_wr_data_o, core_wr_mask_o and core_rdwr_o hold constant from ISSUE until the FSM returns to IDLE.
REQ-021 WAIT -> RESP on core_done_i; core_rd_data_i is captured on that edge.
REQ-022 RESP, one cycle:
- reqG_done_o = 1.
- Read: reqG_rd_data_o updated with the captured data.
- Write: reqG_rd_data_o unchanged.
- Then IDLE.
REQ-023 Minimum spacing: accept to core_valid_o = 1 cycle; core_done_i to reqG_done_o = 1 cycle; back-to-back grants are at least 4 cycles apart.
REQ-024 Outputs for the non-granted port stay 0, except reqN_rd_data_o, which holds its value.
REQ-025 core_done_i outside WAIT is ignored.
REQ-026 A requester dropping valid after its accept has no effect.
REQ-027 Deasserting arb_en_i during WAIT does not cancel the transfer.

Reset
REQ-028 During and after reset:
- State = IDLE.
- All ready/done/err/core_valid_o = 0.
- core_* data = 0; rd_data = 0.
- Pointer = 1; watchdog counter = 0.
REQ-029 Reset mid-transfer returns to IDLE immediately with no done pulse; the core is reset by the same rst_n_i.

Configuration
REQ-030 Macro PSRAM_ARB_WDT_EN, when defined:
- A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
- When the counter reaches TIMEOUT_CYC without core_done_i, the FSM goes to RESP with reqG_err_o = 1 and reqG_rd_data_o = 64'hFFFF_FFFF_FFFF_FFFF for a read.
- If core_done_i and timeout occur in the same cycle, core_done_i wins and err = 0.
- The next grant still waits for core_ready_i.
REQ-031 PSRAM_ARB_WDT_EN undefined: no counter; WAIT only exits on core_done_i; reqN_err_o tied to 0; TIMEOUT_CYC unused.

Verification
REQ-032 Port 0 read at 32'h0000_0100:
- Stimulus: core model returns done 20 cycles after valid, with data 64'h0123_4567_89AB_CDEF.
- Required: req0_done_o is a 1-cycle pulse with req0_rd_data_o = that value, and core_valid_o is a single pulse.
REQ-033 Both ports request writes continuously from reset:
- Required: grants alternate 0,1,0,1.
- core_addr_o and core_wr_data_o match the granted port and stay stable through WAIT.
REQ-034 Request valid while core_ready_i = 0 or arb_en_i = 0 -> no ready pulse; the grant occurs the cycle both are 1.
REQ-035 Reset asserted during WAIT -> all outputs 0 immediately; the next request after release gets granted normally.
REQ-036 PSRAM_ARB_WDT_EN defined, TIMEOUT_CYC = 16, core never completes a read:
- Required: req1_done_o = 1 and req1_err_o = 1 after 16 WAIT cycles, with req1_rd_data_o all ones.
- Variant with core_done_i on cycle 16: err = 0.

Source files
------------

// File: rtl/psram_xfer_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : psram_xfer_arb
// Description : Two-port round-robin arbiter issuing one transfer at a time
//               to a PSRAM core. Optional WAIT watchdog: PSRAM_ARB_WDT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module psram_xfer_arb #(
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        arb_en_i,

    input  logic        req0_valid_i,
    input  logic        req0_rdwr_i,
    input  logic [31:0] req0_addr_i,
    input  logic [63:0] req0_wr_data_i,
    input  logic [7:0]  req0_wr_mask_i,
    output logic        req0_ready_o,
    output logic [63:0] req0_rd_data_o,
    output logic        req0_done_o,
    output logic        req0_err_o,

    input  logic        req1_valid_i,
    input  logic        req1_rdwr_i,
    input  logic [31:0] req1_addr_i,
    input  logic [63:0] req1_wr_data_i,
    input  logic [7:0]  req1_wr_mask_i,
    output logic        req1_ready_o,
    output logic [63:0] req1_rd_data_o,
    output logic        req1_done_o,
    output logic        req1_err_o,

    output logic [31:0] core_addr_o,
    output logic [63:0] core_wr_data_o,
    output logic [7:0]  core_wr_mask_o,
    output logic        core_rdwr_o,
    output logic        core_valid_o,
    input  logic        core_ready_i,
    input  logic        core_done_i,
    input  logic [63:0] core_rd_data_i
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    logic [1:0]  r_state;
    logic        r_last;
    logic        r_gnt;
    logic        r_core_valid;
    logic        r_core_rdwr;
    logic [31:0] r_core_addr;
    logic [63:0] r_core_wdata;
    logic [7:0]  r_core_mask;
    logic [63:0] r_rd0;
    logic [63:0] r_rd1;

    logic        w_grant;
    logic        w_win;
    logic        w_resp;
    logic        w_tmo;
    logic        w_err;
    logic        w_wait_exit;
    logic [63:0] w_rd_cap;

    assign w_grant = (r_state == c_ST_IDLE) && arb_en_i && core_ready_i &&
                     (req0_valid_i || req1_valid_i);
    // On a tie the port that did not win last time is selected.
    assign w_win   = (req0_valid_i && req1_valid_i) ? ~r_last : req1_valid_i;
    assign w_resp  = (r_state == c_ST_RESP);

    assign w_wait_exit = core_done_i || w_tmo;
    assign w_rd_cap    = core_done_i ? core_rd_data_i : {64{1'b1}};

`ifdef PSRAM_ARB_WDT_EN
    logic [15:0] r_wdt_cnt;
    logic [15:0] w_wdt_next;
    logic        r_err;

    assign w_wdt_next = r_wdt_cnt + 16'd1;
    // A completion arriving in the expiry cycle takes precedence.
    assign w_tmo = (r_state == c_ST_WAIT) && !core_done_i && (w_wdt_next == TIMEOUT_CYC);
    assign w_err = r_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wdt_cnt <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == c_ST_ISSUE) begin
                r_wdt_cnt <= 16'd0;
            end else if (r_state == c_ST_WAIT) begin
                r_wdt_cnt <= w_wdt_next;
            end
            if (r_state == c_ST_WAIT) begin
                r_err <= w_tmo;
            end
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_err        = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= c_ST_IDLE;
            r_last       <= 1'b1;
            r_gnt        <= 1'b0;
            r_core_valid <= 1'b0;
            r_core_rdwr  <= 1'b0;
            r_core_addr  <= 32'd0;
            r_core_wdata <= 64'd0;
            r_core_mask  <= 8'd0;
            r_rd0        <= 64'd0;
            r_rd1        <= 64'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= c_ST_ISSUE;
                        r_gnt        <= w_win;
                        r_last       <= w_win;
                        r_core_valid <= 1'b1;
                        r_core_rdwr  <= w_win ? req1_rdwr_i    : req0_rdwr_i;
                        r_core_addr  <= w_win ? req1_addr_i    : req0_addr_i;
                        r_core_wdata <= w_win ? req1_wr_data_i : req0_wr_data_i;
                        r_core_mask  <= w_win ? req1_wr_mask_i : req0_wr_mask_i;
                    end
                end
                c_ST_ISSUE: begin
                    r_core_valid <= 1'b0;
                    r_state      <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (w_wait_exit) begin
                        r_state <= c_ST_RESP;
                        if (r_core_rdwr) begin
                            if (r_gnt) begin
                                r_rd1 <= w_rd_cap;
                            end else begin
                                r_rd0 <= w_rd_cap;
                            end
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready_o   = w_grant && !w_win;
    assign req1_ready_o   = w_grant && w_win;
    assign req0_done_o    = w_resp && !r_gnt;
    assign req1_done_o    = w_resp && r_gnt;
    assign req0_err_o     = w_resp && !r_gnt && w_err;
    assign req1_err_o     = w_resp && r_gnt && w_err;
    assign req0_rd_data_o = r_rd0;
    assign req1_rd_data_o = r_rd1;

    assign core_addr_o    = r_core_addr;
    assign core_wr_data_o = r_core_wdata;
    assign core_wr_mask_o = r_core_mask;
    assign core_rdwr_o    = r_core_rdwr;
    assign core_valid_o   = r_core_valid;

endmodule
`default_nettype wire

// File: tb/tb_psram_xfer_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_psram_xfer_arb
// Description : Randomized scoreboard bench for psram_xfer_arb.
// Revision    : 1.0  initial release
// ============================================================================
module tb_psram_xfer_arb;

    localparam int TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i, arb_en_i;
    logic        req0_valid_i, req0_rdwr_i, req1_valid_i, req1_rdwr_i;
    logic [31:0] req0_addr_i, req1_addr_i;
    logic [63:0] req0_wr_data_i, req1_wr_data_i;
    logic [7:0]  req0_wr_mask_i, req1_wr_mask_i;
    logic        req0_ready_o, req0_done_o, req0_err_o;
    logic        req1_ready_o, req1_done_o, req1_err_o;
    logic [63:0] req0_rd_data_o, req1_rd_data_o;
    logic [31:0] core_addr_o;
    logic [63:0] core_wr_data_o;
    logic [7:0]  core_wr_mask_o;
    logic        core_rdwr_o, core_valid_o;
    logic        core_ready_i, core_done_i;
    logic [63:0] core_rd_data_i;

    psram_xfer_arb #(.TIMEOUT_CYC(16'(TMO))) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .arb_en_i(arb_en_i),
        .req0_valid_i(req0_valid_i), .req0_rdwr_i(req0_rdwr_i), .req0_addr_i(req0_addr_i),
        .req0_wr_data_i(req0_wr_data_i), .req0_wr_mask_i(req0_wr_mask_i),
        .req0_ready_o(req0_ready_o), .req0_rd_data_o(req0_rd_data_o),
        .req0_done_o(req0_done_o), .req0_err_o(req0_err_o),
        .req1_valid_i(req1_valid_i), .req1_rdwr_i(req1_rdwr_i), .req1_addr_i(req1_addr_i),
        .req1_wr_data_i(req1_wr_data_i), .req1_wr_mask_i(req1_wr_mask_i),
        .req1_ready_o(req1_ready_o), .req1_rd_data_o(req1_rd_data_o),
        .req1_done_o(req1_done_o), .req1_err_o(req1_err_o),
        .core_addr_o(core_addr_o), .core_wr_data_o(core_wr_data_o),
        .core_wr_mask_o(core_wr_mask_o), .core_rdwr_o(core_rdwr_o),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_done_i(core_done_i), .core_rd_data_i(core_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        rdwr;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [7:0]  m;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc0    = 0;
    int   acc1    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_err  = 1'b0;
    bit          cur_p  = 1'b0;
    int          m_gcyc = 0;
    int          m_rcyc = -1;
    txn_t        cur;
    logic [63:0] m_rd0 = '0;
    logic [63:0] m_rd1 = '0;
    logic [63:0] m_cap = '0;
    logic [1:0]  e_rdy, e_done, e_err;
    logic        e_cv, e_g, e_w;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            chk("rst_ctl", {req1_ready_o, req1_done_o, req1_err_o, req0_ready_o,
                            req0_done_o, req0_err_o, core_valid_o, core_rdwr_o}, 64'd0);
            chk("rst_core_addr", core_addr_o, 64'd0);
            chk("rst_core_wdata", core_wr_data_o, 64'd0);
            chk("rst_core_mask", core_wr_mask_o, 64'd0);
            chk("rst_rd0", req0_rd_data_o, 64'd0);
            chk("rst_rd1", req1_rd_data_o, 64'd0);
            m_busy = 1'b0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0; m_rcyc = -1;
        end else begin
            e_rdy = 2'b00; e_g = 1'b0; e_w = 1'b0;
            if (!m_busy && arb_en_i && core_ready_i && (req0_valid_i || req1_valid_i)) begin
                e_g   = 1'b1;
                e_w   = (req0_valid_i && req1_valid_i) ? ~m_last : req1_valid_i;
                e_rdy = e_w ? 2'b10 : 2'b01;
            end
            e_cv   = m_busy && (cyc == m_gcyc + 1);
            e_done = 2'b00;
            e_err  = 2'b00;
            if (m_busy && cyc == m_rcyc) begin
                e_done = cur_p ? 2'b10 : 2'b01;
                e_err  = m_err ? e_done : 2'b00;
                if (cur.rdwr) begin
                    if (cur_p) m_rd1 = m_err ? '1 : m_cap;
                    else       m_rd0 = m_err ? '1 : m_cap;
                end
            end
            chk("ready", {req1_ready_o, req0_ready_o}, e_rdy);
            chk("core_valid", core_valid_o, e_cv);
            chk("done", {req1_done_o, req0_done_o}, e_done);
            chk("err", {req1_err_o, req0_err_o}, e_err);
            chk("rd_data0", req0_rd_data_o, m_rd0);
            chk("rd_data1", req1_rd_data_o, m_rd1);
            if (m_busy && cyc > m_gcyc) begin
                chk("core_addr", core_addr_o, cur.addr);
                chk("core_wdata", core_wr_data_o, cur.wd);
                chk("core_mask", core_wr_mask_o, cur.m);
                chk("core_rdwr", core_rdwr_o, cur.rdwr);
            end
            if (req0_ready_o) acc0++;
            if (req1_ready_o) acc1++;
            if (e_done != 2'b00) begin
                m_busy = 1'b0;
            end else if (m_busy && m_rcyc < 0 && cyc >= m_gcyc + 2) begin
                if (core_done_i) begin
                    m_rcyc = cyc + 1; m_cap = core_rd_data_i; m_err = 1'b0;
                end
`ifdef PSRAM_ARB_WDT_EN
                else if (cyc == m_gcyc + 1 + TMO) begin
                    m_rcyc = cyc + 1; m_err = 1'b1;
                end
`endif
            end
            if (e_g) begin
                chk("sb_has_req", (e_w ? q1.size() : q0.size()) != 0, 1);
                if (e_w && q1.size() != 0) cur = q1.pop_front();
                if (!e_w && q0.size() != 0) cur = q0.pop_front();
                cur_p = e_w; m_last = e_w; m_busy = 1'b1;
                m_gcyc = cyc; m_rcyc = -1; m_err = 1'b0;
            end
        end
    end

    // ---------------- stimulus: requesters + core model ----------------
    bit          c_busy = 1'b0;
    bit          first_core = 1'b1;
    bit          first_req = 1'b1;
    bit          gen_en = 1'b1;
    int          c_cnt = 0;
    int          cons0 = 0;
    int          cons1 = 0;
    logic [63:0] c_data;

    function automatic txn_t rand_txn();
        txn_t t;
        t.rdwr = 1'($urandom);
        t.addr = $urandom;
        t.wd   = {$urandom, $urandom};
        t.m    = 8'($urandom);
        return t;
    endfunction

    task automatic step();
        txn_t t;
        core_done_i = 1'b0;
        if (c_busy) begin
            if (req0_done_o || req1_done_o) begin
                c_busy = 1'b0;
            end else begin
                c_cnt--;
                if (c_cnt == 0) begin
                    core_done_i = 1'b1; core_rd_data_i = c_data; c_busy = 1'b0;
                end
            end
        end else if (core_valid_o) begin
            c_busy = 1'b1;
`ifdef PSRAM_ARB_WDT_EN
            c_cnt = $urandom_range(1, 22);
`else
            c_cnt = $urandom_range(1, 8);
`endif
            c_data = {$urandom, $urandom};
            if (first_core) begin
                c_cnt = 20; c_data = 64'h0123_4567_89AB_CDEF; first_core = 1'b0;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            core_done_i = 1'b1; core_rd_data_i = {$urandom, $urandom};
        end
        core_ready_i = !c_busy && ($urandom_range(0, 5) != 0);
        arb_en_i     = ($urandom_range(0, 5) != 0);

        if (acc0 != cons0) begin cons0 = acc0; req0_valid_i = 1'b0; end
        if (!req0_valid_i && gen_en && $urandom_range(0, 3) != 0) begin
            t = rand_txn();
            if (first_req) begin
                t.rdwr = 1'b1; t.addr = 32'h0000_0100; first_req = 1'b0;
            end
            q0.push_back(t);
            req0_valid_i = 1'b1; req0_rdwr_i = t.rdwr; req0_addr_i = t.addr;
            req0_wr_data_i = t.wd; req0_wr_mask_i = t.m;
        end
        if (acc1 != cons1) begin cons1 = acc1; req1_valid_i = 1'b0; end
        if (!req1_valid_i && gen_en && $urandom_range(0, 3) != 0) begin
            t = rand_txn();
            q1.push_back(t);
            req1_valid_i = 1'b1; req1_rdwr_i = t.rdwr; req1_addr_i = t.addr;
            req1_wr_data_i = t.wd; req1_wr_mask_i = t.m;
        end
    endtask

    initial begin
        int k;
        rst_n_i = 1'b0; arb_en_i = 1'b0; core_ready_i = 1'b0; core_done_i = 1'b0;
        core_rd_data_i = '0;
        req0_valid_i = 1'b0; req0_rdwr_i = 1'b0; req0_addr_i = '0; req0_wr_data_i = '0; req0_wr_mask_i = '0;
        req1_valid_i = 1'b0; req1_rdwr_i = 1'b0; req1_addr_i = '0; req1_wr_data_i = '0; req1_wr_mask_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        repeat (3000) begin @(posedge clk_i); #1 step(); end

        // Reset in the middle of a WAIT phase.
        k = 0;
        while (!(c_busy && c_cnt > 3) && k < 2000) begin @(posedge clk_i); #1 step(); k++; end
        chk("find_wait", k < 2000, 1);
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_ctl", {req1_ready_o, req1_done_o, req1_err_o, req0_ready_o,
                            req0_done_o, req0_err_o, core_valid_o}, 64'd0);
        chk("rst_mid_addr", core_addr_o, 64'd0);
        chk("rst_mid_rd0", req0_rd_data_o, 64'd0);
        chk("rst_mid_rd1", req1_rd_data_o, 64'd0);
        c_busy = 1'b0; core_done_i = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        q0.delete(); q1.delete();
        cons0 = acc0; cons1 = acc1;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        repeat (1500) begin @(posedge clk_i); #1 step(); end

        gen_en = 1'b0;
        k = 0;
        while ((m_busy || req0_valid_i || req1_valid_i || c_busy) && k < 1000) begin
            @(posedge clk_i); #1 step(); k++;
        end
        chk("drain", k < 1000, 1);
        chk("sb_left", q0.size() + q1.size(), 0);
        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
